// File: rtl/fifo_deaggregator_pkg.sv
// Shared constants and helpers for the FIFO de-aggregator.
package fifo_deaggregator_pkg;

    localparam int unsigned DefDataWidth  = 11;
    localparam int unsigned DefFetchWidth = 4;

    // Word index width; never zero so FETCH_WIDTH = 1 still has a legal index register.
    function automatic int unsigned idx_width(input int unsigned fetch_width);
        return (fetch_width > 1) ? $clog2(fetch_width) : 1;
    endfunction

endpackage

// File: rtl/fifo_deaggregator_if.sv
// Upstream wide-entry and downstream word handshakes of the de-aggregator.
interface fifo_deaggregator_if
    import fifo_deaggregator_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned FETCH_WIDTH = DefFetchWidth
);

    logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data;
    logic                              sender_empty_n;
    logic                              sender_deq;
    logic [DATA_WIDTH-1:0]             receiver_data;
    logic                              receiver_full_n;
    logic                              receiver_enq;

    modport slave (
        input  sender_data, sender_empty_n, receiver_full_n,
        output sender_deq, receiver_data, receiver_enq
    );

    modport master (
        output sender_data, sender_empty_n, receiver_full_n,
        input  sender_deq, receiver_data, receiver_enq
    );

endinterface

// File: rtl/deagg_word_buffer.sv
// One-entry buffer that hands out its words in ascending index order.
module deagg_word_buffer
    import fifo_deaggregator_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned FETCH_WIDTH = DefFetchWidth
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load_i,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] load_data_i,
    input  logic                              enq_i,
    output logic                              valid_o,
    output logic                              last_o,
    output logic [DATA_WIDTH-1:0]             data_o
);

    localparam int unsigned IdxW = idx_width(FETCH_WIDTH);

    logic [FETCH_WIDTH*DATA_WIDTH-1:0] buf_q, buf_d;
    logic                              valid_q, valid_d;
    logic [IdxW-1:0]                   idx_q, idx_d;

    assign valid_o = valid_q;
    assign last_o  = (idx_q == IdxW'(FETCH_WIDTH - 1));

    always_comb begin
        data_o = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (idx_q == IdxW'(i)) begin
                data_o = buf_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A load on the same edge as the last-word enq wins, so back-to-back entries do not stall.
    always_comb begin
        buf_d   = buf_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        if (enq_i) begin
            if (last_o) begin
                idx_d   = '0;
                valid_d = 1'b0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        if (load_i) begin
            buf_d   = load_data_i;
            valid_d = 1'b1;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            buf_q   <= buf_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/fifo_deaggregator.sv
// Splits wide upstream FIFO entries into single words for a downstream FIFO.
// Define DEAGG_PREFETCH_EN to refill on the last word for sustained 1 word/cycle.
module fifo_deaggregator
    import fifo_deaggregator_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned FETCH_WIDTH = DefFetchWidth
) (
    input logic                 clk,
    input logic                 rst,
    fifo_deaggregator_if.slave  bus_io
);

    logic valid;
    logic last;
    logic enq;
    logic deq;

    assign enq = valid & bus_io.receiver_full_n & ~rst;

`ifdef DEAGG_PREFETCH_EN
    assign deq = bus_io.sender_empty_n & ~rst & (~valid | (last & enq));
`else
    assign deq = bus_io.sender_empty_n & ~rst & ~valid;
`endif

    assign bus_io.receiver_enq = enq;
    assign bus_io.sender_deq   = deq;

    deagg_word_buffer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_word_buffer (
        .clk         (clk),
        .rst         (rst),
        .load_i      (deq),
        .load_data_i (bus_io.sender_data),
        .enq_i       (enq),
        .valid_o     (valid),
        .last_o      (last),
        .data_o      (bus_io.receiver_data)
    );

endmodule

// File: tb/tb_fifo_deaggregator.sv
// Scoreboard bench for fifo_deaggregator; also runs a FETCH_WIDTH=1 instance.
module tb_fifo_deaggregator;
    import fifo_deaggregator_pkg::*;

    localparam int DW = DefDataWidth;
    localparam int FW = DefFetchWidth;

    logic clk;
    logic rst;
    logic rst1;

    int n_checks;
    int n_bad;

    fifo_deaggregator_if #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) bus ();
    fifo_deaggregator_if #(.DATA_WIDTH(8), .FETCH_WIDTH(1))   bus1 ();

    fifo_deaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    fifo_deaggregator #(.DATA_WIDTH(8), .FETCH_WIDTH(1)) dut1 (
        .clk    (clk),
        .rst    (rst1),
        .bus_io (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] exp_q[$];
    int            send_base;
    int            idx_model;
    logic          last_deq;
    logic          last_enq;
    logic [DW-1:0] last_data;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [FW*DW-1:0] build_entry(input int base);
        logic [FW*DW-1:0] e;
        for (int i = 0; i < FW; i++) e[i*DW +: DW] = DW'(base + i);
        return e;
    endfunction

    // One clock of the main DUT: drive, observe at negedge, score, then advance the sender.
    task automatic cycle(input logic r, input logic en, input logic fn);
        logic [DW-1:0] exp_w;
        rst = r;
        bus.sender_empty_n  = en;
        bus.receiver_full_n = fn;
        @(negedge clk);
        last_deq  = bus.sender_deq;
        last_enq  = bus.receiver_enq;
        last_data = bus.receiver_data;
        check_value("deq_gate", {31'b0, last_deq & (~en | r)}, 32'd0);
        if (r) begin
            check_value("rst_enq", {31'b0, last_enq}, 32'd0);
            check_value("rst_data", {21'b0, last_data}, 32'd0);
            exp_q.delete();
            idx_model = 0;
        end
        if (last_deq) begin
            for (int i = 0; i < FW; i++) exp_q.push_back(DW'(send_base + i));
        end
        if (last_enq) begin
            check_value("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                check_value("word", {21'b0, last_data}, {21'b0, exp_w});
            end
            idx_model = (idx_model == FW - 1) ? 0 : idx_model + 1;
        end
        @(posedge clk);
        #1;
        if (last_deq) begin
            send_base += FW;
            bus.sender_data = build_entry(send_base);
        end
    endtask

    initial begin
        int fresh;
        int n;
        logic exp_enq;
        n_checks  = 0;
        n_bad     = 0;
        send_base = 0;
        idx_model = 0;
        rst  = 1'b1;
        rst1 = 1'b1;
        bus.sender_data      = build_entry(0);
        bus.sender_empty_n   = 1'b1;
        bus.receiver_full_n  = 1'b1;
        bus1.sender_data     = 8'h00;
        bus1.sender_empty_n  = 1'b0;
        bus1.receiver_full_n = 1'b1;

        repeat (3) cycle(1'b1, 1'b1, 1'b1);
        rst1 = 1'b0;

        // Two full entries at full speed; idle slot after each entry only without prefetch.
        for (int c = 0; c < 12; c++) begin
            cycle(1'b0, 1'b1, 1'b1);
`ifdef DEAGG_PREFETCH_EN
            exp_enq = (c != 0);
`else
            exp_enq = ((c % (FW + 1)) != 0);
`endif
            check_value("enq_pattern", {31'b0, last_enq}, {31'b0, exp_enq});
        end

        // Random downstream back-pressure.
        for (int c = 0; c < 500; c++) begin
            cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)));
            if (c % 50 == 0) check_value("sb_depth", {31'b0, exp_q.size() <= FW}, 32'd1);
        end

        // Upstream runs dry right after the last word of an entry.
        n = 0;
        while (idx_model != FW - 1 && n < 20) begin
            cycle(1'b0, 1'b1, 1'b1);
            n++;
        end
        check_value("wait_last", idx_model, FW - 1);
        cycle(1'b0, 1'b0, 1'b1);
        check_value("last_word_enq", {31'b0, last_enq}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            cycle(1'b0, 1'b0, 1'b1);
            check_value("dry_deq", {31'b0, last_deq}, 32'd0);
            check_value("dry_enq", {31'b0, last_enq}, 32'd0);
        end
        fresh = send_base;
        cycle(1'b0, 1'b1, 1'b1);
        check_value("resume_deq", {31'b0, last_deq}, 32'd1);
        cycle(1'b0, 1'b1, 1'b1);
        check_value("resume_enq", {31'b0, last_enq}, 32'd1);
        check_value("resume_word0", {21'b0, last_data}, 32'(DW'(fresh)));

        // Reset mid-entry discards the rest of the entry.
        n = 0;
        while (idx_model != 2 && n < 20) begin
            cycle(1'b0, 1'b1, 1'b1);
            n++;
        end
        check_value("wait_idx2", idx_model, 2);
        cycle(1'b1, 1'b1, 1'b1);
        check_value("rst_deq_now", {31'b0, last_deq}, 32'd0);
        fresh = send_base;
        cycle(1'b0, 1'b1, 1'b1);
        check_value("post_rst_deq", {31'b0, last_deq}, 32'd1);
        cycle(1'b0, 1'b1, 1'b1);
        check_value("post_rst_enq", {31'b0, last_enq}, 32'd1);
        check_value("post_rst_word0", {21'b0, last_data}, 32'(DW'(fresh)));

        // Park the main DUT, then exercise the FETCH_WIDTH=1 instance.
        bus.sender_empty_n  = 1'b0;
        bus.receiver_full_n = 1'b0;
        bus1.sender_data    = 8'hA5;
        bus1.sender_empty_n = 1'b1;
        @(negedge clk);
        check_value("fw1_deq_a5", {31'b0, bus1.sender_deq}, 32'd1);
        check_value("fw1_idle_a5", {31'b0, bus1.receiver_enq}, 32'd0);
        @(posedge clk); #1;
        bus1.sender_empty_n = 1'b0;
        @(negedge clk);
        check_value("fw1_enq_a5", {31'b0, bus1.receiver_enq}, 32'd1);
        check_value("fw1_data_a5", {24'b0, bus1.receiver_data}, 32'hA5);
        @(posedge clk); #1;
        bus1.sender_data    = 8'h5A;
        bus1.sender_empty_n = 1'b1;
        @(negedge clk);
        check_value("fw1_deq_5a", {31'b0, bus1.sender_deq}, 32'd1);
        check_value("fw1_idle_5a", {31'b0, bus1.receiver_enq}, 32'd0);
        @(posedge clk); #1;
        bus1.sender_empty_n = 1'b0;
        @(negedge clk);
        check_value("fw1_enq_5a", {31'b0, bus1.receiver_enq}, 32'd1);
        check_value("fw1_data_5a", {24'b0, bus1.receiver_data}, 32'h5A);
        @(posedge clk); #1;
        @(negedge clk);
        check_value("fw1_drained", {31'b0, bus1.receiver_enq}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_deaggregator.md
FIFO_DEAGGREGATOR -- requirements
Module: fifo_deaggregator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 11, width of one output word.
REQ-002 SHALL have parameter FETCH_WIDTH, default 4, number of words per sender entry (legal range 1 to 64).
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- sender_data  input  FETCH_WIDTH*DATA_WIDTH  wide entry from the upstream FWFT FIFO; word i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- sender_empty_n  input  1  upstream entry valid.
- sender_deq  output  1  pop of the upstream entry; sender_data is sampled on the same edge.
- receiver_data  output  DATA_WIDTH  current word.
- receiver_full_n  input  1  downstream can accept.
- receiver_enq  output  1  push receiver_data downstream this cycle.

Function
REQ-005 SHALL hold one entry in a register buf, with a valid flag and a word index idx of max(1, clog2(FETCH_WIDTH)) bits.
REQ-006 SHALL drive receiver_data combinationally as word idx of buf, and receiver_enq = valid AND receiver_full_n AND NOT rst.
REQ-007 SHALL emit words in ascending index order (word 0 first); an entry {3,2,1,0} (word0=0) yields 0,1,2,3.
REQ-008 On receiver_enq with idx < FETCH_WIDTH-1, SHALL increment idx; with idx = FETCH_WIDTH-1, SHALL set idx to 0 and clear valid unless reloaded that same edge.
REQ-009 On sender_deq, SHALL load buf from sender_data, set valid, and set idx to 0.
REQ-010 SHALL present word 0 of a new entry with receiver_enq eligible in the cycle after sender_deq (latency 1).
REQ-011 While receiver_full_n is low, SHALL hold idx, buf, and receiver_data stable, and SHALL not lose or repeat words.
REQ-012 SHALL never assert sender_deq while sender_empty_n is low or while rst is high.
REQ-013 SHALL treat a simultaneous last-word enq and sender_deq as a reload: valid stays 1 and idx becomes 0.
REQ-014 With FETCH_WIDTH = 1, SHALL act as a one-entry pipeline register.

Reset
REQ-015 While rst is high, SHALL set buf to 0, valid to 0, and idx to 0, and SHALL hold sender_deq and receiver_enq at 0.
REQ-016 Reset asserted mid-entry SHALL discard the remaining words; after release, output resumes with the next upstream entry.

Configuration
REQ-017 With macro DEAGG_PREFETCH_EN defined, SHALL set sender_deq = sender_empty_n AND (NOT valid OR (idx = FETCH_WIDTH-1 AND receiver_enq)), giving sustained 1 word/cycle.
REQ-018 Without DEAGG_PREFETCH_EN, SHALL set sender_deq = sender_empty_n AND NOT valid, giving FETCH_WIDTH words per FETCH_WIDTH+1 cycles.

Structure
REQ-019 SHALL place the default DATA_WIDTH/FETCH_WIDTH constants and the index-width function in a shared package, fifo_deaggregator_pkg.
REQ-020 SHALL implement the buffer, valid flag, and idx logic as sub-module deagg_word_buffer; the top level contains only the handshake logic.
REQ-021 The downstream dual-clock FIFO is external to this block and not part of it.

Verification
REQ-022 Reset release, sender_empty_n=1, entries {0,1,2,3},{4,5,6,7}, receiver_full_n=1 -> outputs 0..7 in order; with DEAGG_PREFETCH_EN, receiver_enq is continuous from the first word.
REQ-023 Same stimulus without DEAGG_PREFETCH_EN -> one idle cycle after each word 3 and no data loss.
REQ-024 Random receiver_full_n (50%) over 500 cycles with an incrementing-by-4 sender -> an output sequence counting 0,1,2,... with no gaps or duplicates.
REQ-025 Hold sender_empty_n=0 for 5 cycles after word 3 -> sender_deq=0, receiver_enq=0, and the next entry starts at word 0.
REQ-026 Assert rst while idx=2 -> sender_deq=0 and receiver_enq=0 immediately; after release, the first output is word 0 of a fresh entry.
REQ-027 Run FETCH_WIDTH=1 with DATA_WIDTH=8 and values 0xA5, 0x5A -> outputs 0xA5 then 0x5A, each one cycle after sender_deq.
